// File: rtl/mc_core_pkg.sv
// mc_core_pkg: opcodes, FSM state encoding and instruction field positions
// shared by the mc_core multicycle processor and its register file.
package mc_core_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_ORI   = 4'b0111;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Field layout: op in [3:0], Rb just above it, Ra above Rb, imm is everything above op.
    function automatic int rb_hi(input int reg_aw);
        return 3 + reg_aw;
    endfunction

    function automatic int ra_lo(input int reg_aw);
        return 4 + reg_aw;
    endfunction

    function automatic int ra_hi(input int reg_aw);
        return 3 + 2 * reg_aw;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 2**REG_AW x DATA_W register file, two combinational read ports,
// a debug read port and one synchronous write port; async active-low reset.
module mc_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    input  logic [REG_AW-1:0] i_dbg_sel,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_dbg_data
);
    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/mc_core.sv
// mc_core: parametrised multicycle core with a req/ack single-port memory interface.
// Define MC_CORE_RETIRE_CNT_EN to build the 32-bit retired-instruction counter.
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] pc,
    output logic              flag_n,
    output logic              flag_z,
    output logic              halted,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       retired,
    output logic [2:0]        dbg_state
);
    localparam int RB_HI = rb_hi(REG_AW);
    localparam int RA_LO = ra_lo(REG_AW);
    localparam int RA_HI = ra_hi(REG_AW);
    localparam logic [REG_AW-1:0] ORI_REG = REG_AW'(1);

    state_e            r_state, w_next;
    logic [DATA_W-1:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic              r_n, r_z;

    logic [3:0]        w_op;
    logic [REG_AW-1:0] w_ra, w_rb, w_sel_a;
    logic [DATA_W-1:0] w_imm_z, w_imm_s, w_rd_a, w_rd_b, w_alu, w_wb_data;
    logic              w_is_alu, w_is_branch, w_take, w_rf_we;

    assign w_op    = r_ir[3:0];
    assign w_rb    = r_ir[RB_HI:4];
    assign w_ra    = r_ir[RA_HI:RA_LO];
    assign w_imm_z = {4'b0000, r_ir[DATA_W-1:4]};
    assign w_imm_s = {{4{r_ir[DATA_W-1]}}, r_ir[DATA_W-1:4]};

    assign w_is_alu    = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_NAND) || (w_op == OP_ORI);
    assign w_is_branch = (w_op == OP_BZ) || (w_op == OP_BNZ) || (w_op == OP_BPZ);
    assign w_take      = ((w_op == OP_BZ) && r_z) || ((w_op == OP_BNZ) && !r_z) ||
                         ((w_op == OP_BPZ) && !r_n);

    // ORI reads and writes R1 no matter what the Ra bits hold.
    assign w_sel_a   = (w_op == OP_ORI) ? ORI_REG : w_ra;
    assign w_wb_data = (w_op == OP_LOAD) ? r_mdr : r_aluout;
    assign w_rf_we   = (r_state == S_WB);

    mc_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .i_clk      (CLOCK_50),
        .i_rst_n    (resetn),
        .i_we       (w_rf_we),
        .i_waddr    (w_sel_a),
        .i_wdata    (w_wb_data),
        .i_raddr_a  (w_sel_a),
        .i_raddr_b  (w_rb),
        .i_dbg_sel  (dbg_sel),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .o_dbg_data (dbg_data)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_NAND: w_alu = ~(r_a & r_b);
            OP_ORI:  w_alu = r_a | w_imm_z;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_alu || w_is_branch)                   w_next = S_EXEC;
                else if (w_op == OP_LOAD || w_op == OP_STORE) w_next = S_MEM;
                else if (w_op == OP_STOP)                      w_next = S_HALT;
                else                                           w_next = S_FETCH;
            end
            S_EXEC:   w_next = w_is_alu ? S_WB : S_FETCH;
            S_MEM:    if (mem_ack) w_next = (w_op == OP_LOAD) ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Gating with resetn drops the request the instant reset asserts.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = r_a;
        if (r_state == S_FETCH) begin
            mem_req = resetn;
        end else if (r_state == S_MEM) begin
            mem_req  = resetn;
            mem_we   = (w_op == OP_STORE);
            mem_addr = r_b;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_FETCH;
        else         r_state <= w_next;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ack) begin
                    r_ir <= mem_rdata;
                    r_pc <= r_pc + DATA_W'(1);
                end
                S_DECODE: begin
                    r_a <= w_rd_a;
                    r_b <= w_rd_b;
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    if (w_is_branch && w_take) r_pc <= r_pc + w_imm_s;
                end
                S_MEM: if (mem_ack && (w_op == OP_LOAD)) r_mdr <= mem_rdata;
                S_WB: if (w_is_alu) begin
                    r_n <= w_wb_data[DATA_W-1];
                    r_z <= (w_wb_data == '0);
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CORE_RETIRE_CNT_EN
    logic        w_retire;
    logic [31:0] r_retired;

    // An instruction retires when it leaves for FETCH, or when STOP enters HALT.
    assign w_retire = (r_state != S_FETCH) && (r_state != S_HALT) &&
                      ((w_next == S_FETCH) || (w_next == S_HALT));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)       r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 32'd1;
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

    assign pc        = r_pc;
    assign flag_n    = r_n;
    assign flag_z    = r_z;
    assign halted    = (r_state == S_HALT);
    assign dbg_state = r_state;

endmodule
